// File: rtl/dsf_dac_pkg.sv
// Shared types and constants for the sine sample to SPI DAC stage.
package dsf_dac_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } dac_state_t;

  localparam int          DAC_FRAME_BITS = 16;
  localparam logic [11:0] OFFSET_BIN_XOR = 12'h800;
  // {A/B=0, BUF=0, GA=1x, SHDN=active}
  localparam logic [3:0]  DEF_CFG_BITS   = 4'b0011;

endpackage

// File: rtl/clk_div_tick.sv
// Down-counter producing a one-cycle tick every CLK_DIV clocks.
// A load restarts the count so the first tick lands CLK_DIV clocks later.
module clk_div_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  output logic tick
);

  localparam int             CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Reload on request or on terminal count, otherwise count down
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                 cnt <= TOP;
    else if (load || cnt == '0)  cnt <= TOP;
    else                         cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/sine_dac_spi.sv
// Sine sample to SPI DAC serialiser: one-entry input buffer, offset-binary
// conversion and a 16-bit MCP4921-style write frame, SPI mode 0, MSB first.
// Optional: define LDAC_PULSE_EN to drive an LDAC low pulse after each frame
// (otherwise spi_ldacn is tied low and the DAC updates on csn rise).
module sine_dac_spi
  import dsf_dac_pkg::*;
#(
  parameter int         width    = 12,
  parameter int         CLK_DIV  = 4,
  parameter int         CS_GAP   = 4,
  parameter logic [3:0] CFG_BITS = DEF_CFG_BITS
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [width-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             spi_sclk,
  output logic             spi_mosi,
  output logic             spi_csn,
  output logic             spi_ldacn,
  output logic             frame_done
);

`ifdef LDAC_PULSE_EN
  // GAP must be long enough to contain the LDAC pulse plus one clear clock
  localparam int GAP_LEN = (CS_GAP > CLK_DIV + 1) ? CS_GAP : CLK_DIV + 1;
`else
  localparam int GAP_LEN = CS_GAP;
`endif
  localparam int            GW       = $clog2(GAP_LEN + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);

  dac_state_t                state, state_nxt;
  logic                      pend_full;
  logic [DAC_FRAME_BITS-1:0] pend_word;
  logic [DAC_FRAME_BITS-1:0] shreg;
  logic [3:0]                bit_cnt;
  logic [GW-1:0]             gap_cnt;
  logic                      tick, load, accept, pop, csn_low;

  assign sample_ready = !pend_full;
  assign accept       = sample_valid && !pend_full;
  assign pop          = (state == IDLE) && pend_full;

  // Phase timer restarts on every state change
  assign load = (state_nxt != state);

  clk_div_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .load   (load),
    .tick   (tick)
  );

  // One-entry pending buffer; accept and pop are mutually exclusive
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_full <= 1'b0;
      pend_word <= '0;
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_word <= {CFG_BITS, sample_in ^ OFFSET_BIN_XOR};
    end else if (pop) begin
      pend_full <= 1'b0;
    end
  end

  // Shift register and bit counter; shift on the end of each high phase
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      shreg   <= pend_word;
      bit_cnt <= 4'd15;
    end else if (state == SHIFT_HI && tick && bit_cnt != 4'd0) begin
      shreg   <= {shreg[DAC_FRAME_BITS-2:0], 1'b0};
      bit_cnt <= bit_cnt - 4'd1;
    end
  end

  // Cycle index within GAP
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)           gap_cnt <= '0;
    else if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
    else                   gap_cnt <= '0;
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pend_full) state_nxt = SETUP;
      SETUP:    if (tick) state_nxt = SHIFT_HI;
      SHIFT_HI: if (tick) state_nxt = (bit_cnt == 4'd0) ? HOLD : SHIFT_LO;
      SHIFT_LO: if (tick) state_nxt = SHIFT_HI;
      HOLD:     if (tick) state_nxt = GAP;
      GAP:      if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode; mosi is parked low whenever csn is high
  always_comb begin
    csn_low    = (state == SETUP) || (state == SHIFT_HI) ||
                 (state == SHIFT_LO) || (state == HOLD);
    spi_csn    = !csn_low;
    spi_sclk   = (state == SHIFT_HI);
    spi_mosi   = csn_low && shreg[DAC_FRAME_BITS-1];
    frame_done = (state == GAP) && (gap_cnt == '0);
`ifdef LDAC_PULSE_EN
    spi_ldacn  = !((state == GAP) && (gap_cnt < GW'(CLK_DIV)));
`else
    spi_ldacn  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_sine_dac_spi.sv
// Scoreboard bench for sine_dac_spi: stimulus pushes expected frame words,
// a negedge monitor reconstructs frames from the SPI pins and compares.
module tb_sine_dac_spi;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 4;
`ifdef LDAC_PULSE_EN
  localparam int   GAP_LEN   = (CS_GAP > CLK_DIV + 1) ? CS_GAP : CLK_DIV + 1;
  localparam logic LDAC_RST  = 1'b1;
`else
  localparam int   GAP_LEN   = CS_GAP;
  localparam logic LDAC_RST  = 1'b0;
`endif
  localparam int LOW_LEN = 33 * CLK_DIV;
  localparam int PERIOD  = LOW_LEN + GAP_LEN + 1;

  logic        clock, resetn;
  logic [11:0] sample_in;
  logic        sample_valid, sample_ready;
  logic        spi_sclk, spi_mosi, spi_csn, spi_ldacn, frame_done;

  sine_dac_spi #(.width(12), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_csn      (spi_csn),
    .spi_ldacn    (spi_ldacn),
    .frame_done   (frame_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          total = 0;
  int          bad   = 0;
  logic [15:0] expq[$];
  int          falls[$];
  int          cyc   = 0;
  int          m_low = 0;
  int          m_nb  = 0;
  int          m_ldac_low = 0;
  logic        m_pcsn = 1'b1;
  logic        m_psclk = 1'b0;
  logic        m_cap = 1'b0;
  logic [15:0] m_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: offset binary is the signed value plus half scale
  function automatic logic [15:0] model(input logic [11:0] s);
    int v;
    v = $signed(s) + 2048;
    return {4'b0011, v[11:0]};
  endfunction

  // Monitor: rebuild frames from pins, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!resetn) begin
        m_pcsn = 1'b1; m_psclk = 1'b0; m_cap = 1'b0;
        m_nb = 0; m_low = 0; m_ldac_low = 0;
      end else begin
        if (m_pcsn && !spi_csn) begin
          m_cap = 1'b1; m_nb = 0; m_low = 0;
          falls.push_back(cyc);
        end
        if (!spi_csn) m_low++;
        if (!spi_csn && spi_sclk && !m_psclk) begin
          m_word = {m_word[14:0], spi_mosi};
          m_nb++;
        end
        if (!m_pcsn && spi_csn && m_cap) begin
          m_cap = 1'b0;
          chk("bit_count", m_nb, 16);
          chk("csn_low_clocks", m_low, LOW_LEN);
          chk("frame_done_at_gap", frame_done, 1'b1);
          chk("ldacn_at_gap", spi_ldacn, 1'b0);
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame: got %h want none", m_word);
          end else begin
            chk("frame_word", m_word, expq.pop_front());
          end
        end else if (frame_done) begin
          chk("frame_done_extra", frame_done, 1'b0);
        end
`ifdef LDAC_PULSE_EN
        if (!spi_ldacn) m_ldac_low++;
        else if (m_ldac_low != 0) begin
          chk("ldacn_low_clocks", m_ldac_low, CLK_DIV);
          m_ldac_low = 0;
        end
`else
        if (spi_ldacn) chk("ldacn_tied", spi_ldacn, 1'b0);
`endif
        m_pcsn  = spi_csn;
        m_psclk = spi_sclk;
      end
    end
  end

  // Offer one sample; called at a falling edge, returns at a falling edge
  task automatic send(input logic [11:0] s);
    int n = 0;
    sample_in    = s;
    sample_valid = 1'b1;
    while (!sample_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!sample_ready) begin
      chk("ready_timeout", sample_ready, 1'b1);
      sample_valid = 1'b0;
      return;
    end
    expq.push_back(model(s));
    @(negedge clock);
    sample_valid = 1'b0;
    chk("ready_after_accept", sample_ready, 1'b0);
  endtask

  // Wait for all expected frames to appear, then for the gap to finish
  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || !spi_csn) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", expq.size(), 0);
    repeat (GAP_LEN + 2) @(negedge clock);
  endtask

  initial begin
    logic [11:0] dir[4];
    int nsclk, ncsn, n;
    resetn       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    dir[0] = 12'h000; dir[1] = 12'h800; dir[2] = 12'h7FF; dir[3] = 12'hFFF;

    #995;
    chk("rst_csn", spi_csn, 1'b1);
    chk("rst_sclk", spi_sclk, 1'b0);
    chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_ready", sample_ready, 1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_ldacn", spi_ldacn, LDAC_RST);
    #5 resetn = 1'b1;

    // Quiet after reset
    nsclk = 0; ncsn = 0;
    repeat (200) begin
      @(negedge clock);
      if (spi_sclk) nsclk++;
      if (!spi_csn) ncsn++;
    end
    chk("idle_sclk_high", nsclk, 0);
    chk("idle_csn_low", ncsn, 0);

    // Directed single frames, including the offset-binary extremes
    foreach (dir[i]) begin
      send(dir[i]);
      drain();
    end

    // Back-to-back: valid held, frames must be contiguous
    falls.delete();
    send(12'h123);
    send(12'hABC);
    send(12'h5A5);
    drain();
    chk("b2b_frames", falls.size(), 3);
    if (falls.size() == 3) begin
      chk("b2b_period_1", falls[1] - falls[0], PERIOD);
      chk("b2b_period_2", falls[2] - falls[1], PERIOD);
    end

    // Random samples with random spacing
    repeat (6) begin
      send(12'($urandom));
      repeat ($urandom_range(0, 160)) @(negedge clock);
    end
    drain();

    // Reset during bit 7 with a sample pending
    send(12'h3C3);
    send(12'h0F0);
    n = 0;
    while (m_low < 70 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("reach_bit7", (m_low >= 70), 1'b1);
    @(posedge clock);
    #2 resetn = 1'b0;
    expq.delete();
    #1;
    chk("midrst_csn", spi_csn, 1'b1);
    chk("midrst_sclk", spi_sclk, 1'b0);
    chk("midrst_ready", sample_ready, 1'b1);
    chk("midrst_ldacn", spi_ldacn, LDAC_RST);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (!spi_csn) ncsn++;
    end
    chk("post_rst_idle_csn", spi_csn, 1'b1);
    send(12'h456);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
